// File: rtl/rv_pkg.sv
// rv_pkg: shared FSM state type, mem_op encodings and load/store lane helpers (Rev 1.0).
`default_nettype none

package rv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_WAIT = 2'd1,
        ST_LS_WAIT = 2'd2
    } state_e;

    localparam logic [2:0] MEM_B  = 3'd0;
    localparam logic [2:0] MEM_H  = 3'd1;
    localparam logic [2:0] MEM_W  = 3'd2;
    localparam logic [2:0] MEM_BU = 3'd4;
    localparam logic [2:0] MEM_HU = 3'd5;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } st_lanes_t;

    function automatic logic op_legal(input logic [2:0] op, input logic we);
        case (op)
            MEM_B, MEM_H, MEM_W: op_legal = 1'b1;
            MEM_BU, MEM_HU:      op_legal = !we;
            default:             op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op)
            MEM_H, MEM_HU: misaligned = addr_lo[0];
            MEM_W:         misaligned = |addr_lo;
            default:       misaligned = 1'b0;
        endcase
    endfunction

    // Halfword selection uses addr[1] only, so unaligned accesses are force-aligned.
    function automatic logic [31:0] ld_extend(input logic [2:0] op, input logic [1:0] addr_lo,
                                              input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = word >> {addr_lo, 3'b000};
        b       = shifted[7:0];
        h       = addr_lo[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_B:   ld_extend = {{24{b[7]}}, b};
            MEM_H:   ld_extend = {{16{h[15]}}, h};
            MEM_BU:  ld_extend = {24'd0, b};
            MEM_HU:  ld_extend = {16'd0, h};
            default: ld_extend = word;
        endcase
    endfunction

    function automatic st_lanes_t st_lanes(input logic [2:0] op, input logic [1:0] addr_lo,
                                           input logic [31:0] data);
        st_lanes_t r;
        case (op)
            MEM_B: begin
                r.be    = 4'b0001 << addr_lo;
                r.wdata = {4{data[7:0]}};
            end
            MEM_H: begin
                r.be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                r.wdata = {2{data[15:0]}};
            end
            default: begin
                r.be    = 4'hF;
                r.wdata = data;
            end
        endcase
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_fmt.sv
// lsu_fmt: combinational store byte-lane generator and load extender (Rev 1.0).
`default_nettype none

module lsu_fmt
    import rv_pkg::*;
(
    input  logic [2:0]  st_op,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    st_lanes_t lanes;

    assign lanes    = st_lanes(st_op, st_addr_lo, st_data);
    assign st_be    = lanes.be;
    assign st_wdata = lanes.wdata;
    assign ld_data  = ld_extend(ld_op, ld_addr_lo, ld_word);

endmodule

`default_nettype wire

// File: rtl/lsu_bus_arb.sv
// lsu_bus_arb: fetch vs load/store bus arbiter with ack timeout (Rev 1.0).
// Option macro: LSU_BUS_ARB_MISALIGN_CHECK_EN aborts misaligned halfword/word accesses.
`default_nettype none

module lsu_bus_arb
    import rv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_rdy,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [2:0]  ls_mem_op,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_rdy,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic        if_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_e      state;
    logic [7:0]  cnt;
    logic [2:0]  op_q;
    logic [1:0]  alo_q;
    logic        we_q;
    logic        ls_abort;
    logic        timed_out;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic        unused_bits;

    assign unused_bits = ^if_addr[1:0];

`ifdef LSU_BUS_ARB_MISALIGN_CHECK_EN
    assign ls_abort = !op_legal(ls_mem_op, ls_we) || misaligned(ls_mem_op, ls_addr[1:0]);
`else
    assign ls_abort = !op_legal(ls_mem_op, ls_we);
`endif

    assign timed_out = (cnt == TIMEOUT_CNT);

    lsu_fmt u_fmt (
        .st_op      (ls_mem_op),
        .st_addr_lo (ls_addr[1:0]),
        .st_data    (ls_wdata),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_op      (op_q),
        .ld_addr_lo (alo_q),
        .ld_word    (bus_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            op_q      <= 3'd0;
            alo_q     <= 2'd0;
            we_q      <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_be    <= 4'd0;
            if_rdy    <= 1'b0;
            ls_rdy    <= 1'b0;
            if_rdata  <= 32'd0;
            ls_rdata  <= 32'd0;
            ls_err    <= 1'b0;
            if_err    <= 1'b0;
        end else begin
            if_rdy <= 1'b0;
            ls_rdy <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A requester whose rdy is still high is not re-accepted.
                    if (ls_req && !ls_rdy) begin
                        if (ls_abort) begin
                            ls_rdy   <= 1'b1;
                            ls_err   <= 1'b1;
                            ls_rdata <= 32'd0;
                        end else begin
                            state     <= ST_LS_WAIT;
                            cnt       <= 8'd0;
                            op_q      <= ls_mem_op;
                            alo_q     <= ls_addr[1:0];
                            we_q      <= ls_we;
                            bus_req   <= 1'b1;
                            bus_we    <= ls_we;
                            bus_addr  <= {ls_addr[31:2], 2'b00};
                            bus_be    <= ls_we ? st_be : 4'hF;
                            bus_wdata <= ls_we ? st_wdata : 32'd0;
                        end
                    end else if (if_req && !if_rdy) begin
                        state     <= ST_IF_WAIT;
                        cnt       <= 8'd0;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_addr  <= {if_addr[31:2], 2'b00};
                        bus_be    <= 4'hF;
                        bus_wdata <= 32'd0;
                    end
                end
                ST_IF_WAIT: begin
                    if (bus_ack || timed_out) begin
                        state    <= ST_IDLE;
                        bus_req  <= 1'b0;
                        if_rdy   <= 1'b1;
                        if_err   <= !bus_ack;
                        if_rdata <= bus_ack ? bus_rdata : 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_LS_WAIT: begin
                    if (bus_ack || timed_out) begin
                        state    <= ST_IDLE;
                        bus_req  <= 1'b0;
                        bus_we   <= 1'b0;
                        ls_rdy   <= 1'b1;
                        ls_err   <= !bus_ack;
                        ls_rdata <= (bus_ack && !we_q) ? ld_data : 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_arb.sv
// tb_lsu_bus_arb: randomized self-checking bench with a behavioural bus/extension model (Rev 1.0).
`default_nettype none

module tb_lsu_bus_arb;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_rdy;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [2:0]  ls_mem_op = 3'd0;
    logic [31:0] ls_addr = 32'd0;
    logic [31:0] ls_wdata = 32'd0;
    logic        ls_rdy;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        if_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int n_vec = 0;
    int n_err = 0;

    lsu_bus_arb #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdy(if_rdy), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_mem_op(ls_mem_op), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdy(ls_rdy), .ls_rdata(ls_rdata), .ls_err(ls_err),
        .if_err(if_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rd);
        int unsigned byte_v, half_v;
        byte_v = (rd >> (8 * (addr % 4))) & 32'hFF;
        half_v = (rd >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (op)
            3'd0:    return (byte_v >= 128) ? (byte_v | 32'hFFFF_FF00) : byte_v;
            3'd1:    return (half_v >= 32768) ? (half_v | 32'hFFFF_0000) : half_v;
            3'd4:    return byte_v;
            3'd5:    return half_v;
            default: return rd;
        endcase
    endfunction

    // One transaction: request, bus-side checks every wait cycle, ack after `delay` cycles.
    task automatic access(input bit is_ls, input bit we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int delay, input logic [31:0] rd);
        logic [7:0]  ld_ok;
        logic [7:0]  st_ok;
        bit          legal, mis, abort, acked;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        ld_ok = 8'b0011_0111;
        st_ok = 8'b0000_0111;
        legal = we ? st_ok[op] : ld_ok[op];
        mis   = ((op == 3'd1 || op == 3'd5) && addr[0]) || (op == 3'd2 && addr[1:0] != 2'd0);
        abort = is_ls && !legal;
`ifdef LSU_BUS_ARB_MISALIGN_CHECK_EN
        if (is_ls && mis) abort = 1'b1;
`endif
        exp_be = 4'hF;
        exp_wd = wd;
        if (is_ls && we) begin
            if (op == 3'd0) begin
                exp_be = 4'(1 << (addr % 4));
                exp_wd = (wd & 32'hFF) * 32'h0101_0101;
            end else if (op == 3'd1) begin
                exp_be = 4'(3 << (2 * ((addr / 2) % 2)));
                exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
            end
        end
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_mem_op = op; ls_addr = addr; ls_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        tick();
        if (abort) begin
            chk("abort_rdy", 32'(ls_rdy), 32'd1);
            chk("abort_err", 32'(ls_err), 32'd1);
            chk("abort_rdata", ls_rdata, 32'd0);
            chk("abort_nobus", 32'(bus_req), 32'd0);
            ls_req = 1'b0;
        end else begin
            acked = 1'b0;
            for (int i = 0; i <= TO; i++) begin
                chk("bus_req", 32'(bus_req), 32'd1);
                chk("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
                chk("bus_we", 32'(bus_we), 32'(is_ls && we));
                chk("bus_be", 32'(bus_be), 32'(exp_be));
                if (is_ls && we) chk("bus_wdata", bus_wdata, exp_wd);
                if (i == delay) begin
                    bus_ack = 1'b1; bus_rdata = rd; acked = 1'b1;
                end
                tick();
                bus_ack = 1'b0;
                bus_rdata = $urandom;
                if (acked) break;
            end
            chk("bus_req_drop", 32'(bus_req), 32'd0);
            if (is_ls) begin
                chk("ls_rdy", 32'(ls_rdy), 32'd1);
                chk("if_rdy_quiet", 32'(if_rdy), 32'd0);
                chk("ls_err", 32'(ls_err), 32'(!acked));
                if (!acked) chk("ls_rdata_to", ls_rdata, 32'd0);
                else if (!we) chk("ls_rdata", ls_rdata, model_load(op, addr, rd));
                ls_req = 1'b0;
            end else begin
                chk("if_rdy", 32'(if_rdy), 32'd1);
                chk("ls_rdy_quiet", 32'(ls_rdy), 32'd0);
                chk("if_err", 32'(if_err), 32'(!acked));
                chk("if_rdata", if_rdata, acked ? rd : 32'd0);
                if_req = 1'b0;
            end
        end
        // Idle cycle with a stray ack that must be ignored.
        bus_ack = 1'($urandom % 2);
        tick();
        bus_ack = 1'b0;
        chk("idle_noreq", 32'(bus_req), 32'd0);
        chk("idle_nordy", 32'({if_rdy, ls_rdy}), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_ctrl", 32'({bus_req, bus_we, bus_be, if_rdy, ls_rdy, ls_err, if_err}), 32'd0);
        chk("rst_addr", bus_addr | bus_wdata, 32'd0);
        chk("rst_rdata", if_rdata | ls_rdata, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        access(1, 0, 3'd2, 32'h100, 0, 0, 32'h80FF_7F01);
        access(1, 0, 3'd0, 32'h103, 0, 0, 32'h80FF_7F01);
        access(1, 0, 3'd4, 32'h103, 0, 1, 32'h80FF_7F01);
        access(1, 1, 3'd1, 32'h202, 32'h1234_ABCD, 2, 0);
        access(1, 0, 3'd2, 32'h101, 0, 0, 32'hCAFE_F00D);
        access(1, 0, 3'd3, 32'h100, 0, 0, 0);
        access(1, 1, 3'd4, 32'h100, 0, 0, 0);
        access(0, 0, 3'd0, 32'h400, 0, 99, 0);
        access(0, 0, 3'd0, 32'h404, 0, TO, 32'h0000_0013);
        access(1, 1, 3'd0, 32'h311, 32'h0000_00A5, 99, 0);

        // Simultaneous requests: load/store first, fetch right after ls_rdy.
        ls_req = 1'b1; ls_we = 1'b0; ls_mem_op = 3'd2; ls_addr = 32'h300;
        if_req = 1'b1; if_addr = 32'h504;
        tick();
        chk("both_ls_addr", bus_addr, 32'h300);
        chk("both_ls_we", 32'(bus_we), 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
        tick();
        bus_ack = 1'b0;
        chk("both_ls_rdy", 32'(ls_rdy), 32'd1);
        chk("both_ls_rdata", ls_rdata, 32'h1122_3344);
        chk("both_if_wait", 32'(if_rdy), 32'd0);
        ls_req = 1'b0;
        tick();
        chk("both_if_req", 32'(bus_req), 32'd1);
        chk("both_if_addr", bus_addr, 32'h504);
        bus_ack = 1'b1; bus_rdata = 32'h0000_0073;
        tick();
        bus_ack = 1'b0;
        chk("both_if_rdy", 32'(if_rdy), 32'd1);
        chk("both_if_rdata", if_rdata, 32'h0000_0073);
        if_req = 1'b0;
        tick();

        for (int n = 0; n < 60; n++) begin
            access(1'($urandom % 2), 1'($urandom % 2), 3'($urandom % 8), $urandom,
                   $urandom, int'($urandom_range(0, 6)), $urandom);
        end

        // Reset during a fetch wait.
        if_req = 1'b1; if_addr = 32'h800;
        tick();
        chk("midrst_req", 32'(bus_req), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", 32'({bus_req, bus_we, bus_be, if_rdy, ls_rdy, ls_err, if_err}), 32'd0);
        chk("midrst_addr", bus_addr | bus_wdata, 32'd0);
        chk("midrst_rdata", if_rdata | ls_rdata, 32'd0);
        if_req = 1'b0;
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("postrst_quiet", 32'({bus_req, if_rdy, ls_rdy}), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
